// File: rtl/ex_operand_stage_if.sv
// Signal bundle for the ID/EX operand stage: decoder inputs, MEM/WB writeback
// taps, external back-pressure and the registered EX-side outputs.
interface ex_operand_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned RADDR = 5,
  parameter int unsigned CNTW  = 16
);
  logic                  id_valid;
  logic [NSRC*RADDR-1:0] id_rs;
  logic [NSRC*XLEN-1:0]  id_rdata;
  logic [XLEN-1:0]       id_imm;
  logic                  id_alusrc;
  logic [RADDR-1:0]      id_rd;
  logic                  id_regwrite;
  logic                  id_load;
  logic [RADDR-1:0]      mem_rd;
  logic                  mem_regwrite;
  logic [XLEN-1:0]       mem_result;
  logic [RADDR-1:0]      wb_rd;
  logic                  wb_regwrite;
  logic [XLEN-1:0]       wb_result;
  logic                  ex_flush;
  logic                  ext_stall;
  logic                  stall_id;
  logic                  ex_valid;
  logic [RADDR-1:0]      ex_rd;
  logic                  ex_regwrite;
  logic                  ex_load;
  logic [NSRC*XLEN-1:0]  ex_src;
  logic [NSRC*2-1:0]     ex_fwd;
  logic [XLEN-1:0]       ex_alu_b;
  logic [XLEN-1:0]       ex_wdata;
  logic [CNTW-1:0]       lu_count;

  modport master (
    output id_valid, id_rs, id_rdata, id_imm, id_alusrc, id_rd, id_regwrite, id_load,
           mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result,
           ex_flush, ext_stall,
    input  stall_id, ex_valid, ex_rd, ex_regwrite, ex_load, ex_src, ex_fwd,
           ex_alu_b, ex_wdata, lu_count
  );

  modport slave (
    input  id_valid, id_rs, id_rdata, id_imm, id_alusrc, id_rd, id_regwrite, id_load,
           mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result,
           ex_flush, ext_stall,
    output stall_id, ex_valid, ex_rd, ex_regwrite, ex_load, ex_src, ex_fwd,
           ex_alu_b, ex_wdata, lu_count
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: EX register, MEM/WB forwarding, load-use bubbles and an
// operand latch that freezes forwarded values while downstream memory is busy.
module ex_operand_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned RADDR = 5,
  parameter int unsigned CNTW  = 16
) (
  input logic               clk,
  input logic               rst,
  ex_operand_stage_if.slave bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [NSRC*RADDR-1:0] ex_rs_q, ex_rs_d;
  logic [NSRC*XLEN-1:0]  ex_rdata_q, ex_rdata_d;
  logic [XLEN-1:0]       ex_imm_q, ex_imm_d;
  logic                  ex_alusrc_q, ex_alusrc_d;
  logic [RADDR-1:0]      ex_rd_q, ex_rd_d;
  logic                  ex_regwrite_q, ex_regwrite_d;
  logic                  ex_load_q, ex_load_d;
  logic [NSRC*XLEN-1:0]  latch_q, latch_d;
  logic [CNTW-1:0]       lu_count_q, lu_count_d;

  logic [NSRC*2-1:0]     fwd_run;
  logic [NSRC*XLEN-1:0]  src_run;
  logic [NSRC*XLEN-1:0]  src_out;
  logic [RADDR-1:0]      rs_k;
  logic                  id_dep;
  logic                  load_use;
  logic                  take_id;
  logic                  bubble;

  // Forwarding from the live EX register; x0 and empty EX never forward.
  always_comb begin
    fwd_run = '0;
    src_run = '0;
    rs_k    = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      rs_k = ex_rs_q[k*RADDR +: RADDR];
      if (ex_valid_q && (rs_k != '0) && bus.mem_regwrite && (bus.mem_rd == rs_k)) begin
        fwd_run[k*2 +: 2]    = 2'b10;
        src_run[k*XLEN +: XLEN] = bus.mem_result;
      end else if (ex_valid_q && (rs_k != '0) && bus.wb_regwrite && (bus.wb_rd == rs_k)) begin
        fwd_run[k*2 +: 2]    = 2'b01;
        src_run[k*XLEN +: XLEN] = bus.wb_result;
      end else begin
        fwd_run[k*2 +: 2]    = 2'b00;
        src_run[k*XLEN +: XLEN] = ex_rdata_q[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    id_dep = 1'b0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (bus.id_rs[k*RADDR +: RADDR] == ex_rd_q) id_dep = 1'b1;
    end
  end

  assign load_use = ex_valid_q && ex_load_q && (ex_rd_q != '0) && bus.id_valid && id_dep;

  assign src_out         = (state_q == HOLD) ? latch_q : src_run;
  assign bus.ex_src      = src_out;
  assign bus.ex_fwd      = (state_q == HOLD) ? '0 : fwd_run;
  assign bus.ex_wdata    = src_out[XLEN +: XLEN];
  assign bus.ex_alu_b    = ex_alusrc_q ? ex_imm_q : src_out[XLEN +: XLEN];
  assign bus.stall_id    = (state_q == HOLD) || load_use;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_regwrite = ex_regwrite_q;
  assign bus.ex_load     = ex_load_q;
  assign bus.lu_count    = lu_count_q;

  // Entering HOLD keeps the EX instruction in place; only the operands are
  // snapshotted, since MEM/WB move on underneath the frozen EX stage.
  always_comb begin
    state_d       = state_q;
    ex_valid_d    = ex_valid_q;
    ex_rs_d       = ex_rs_q;
    ex_rdata_d    = ex_rdata_q;
    ex_imm_d      = ex_imm_q;
    ex_alusrc_d   = ex_alusrc_q;
    ex_rd_d       = ex_rd_q;
    ex_regwrite_d = ex_regwrite_q;
    ex_load_d     = ex_load_q;
    latch_d       = latch_q;
    lu_count_d    = lu_count_q;
    take_id       = 1'b0;
    bubble        = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.ext_stall) begin
          state_d = HOLD;
          latch_d = src_run;
        end else if (bus.ex_flush) begin
          bubble = 1'b1;
        end else if (load_use) begin
          bubble     = 1'b1;
          lu_count_d = (lu_count_q == '1) ? lu_count_q : lu_count_q + 1'b1;
        end else begin
          take_id = 1'b1;
        end
      end
      HOLD: begin
        if (!bus.ext_stall) begin
          state_d = RUN;
          take_id = 1'b1;
        end
      end
    endcase

    if (take_id) begin
      ex_valid_d    = bus.id_valid;
      ex_rs_d       = bus.id_rs;
      ex_rdata_d    = bus.id_rdata;
      ex_imm_d      = bus.id_imm;
      ex_alusrc_d   = bus.id_alusrc;
      ex_rd_d       = bus.id_rd;
      ex_regwrite_d = bus.id_valid && bus.id_regwrite;
      ex_load_d     = bus.id_valid && bus.id_load;
    end

    if (bubble) begin
      ex_valid_d    = 1'b0;
      ex_rs_d       = '0;
      ex_rdata_d    = '0;
      ex_imm_d      = '0;
      ex_alusrc_d   = 1'b0;
      ex_rd_d       = '0;
      ex_regwrite_d = 1'b0;
      ex_load_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      ex_valid_q    <= 1'b0;
      ex_rs_q       <= '0;
      ex_rdata_q    <= '0;
      ex_imm_q      <= '0;
      ex_alusrc_q   <= 1'b0;
      ex_rd_q       <= '0;
      ex_regwrite_q <= 1'b0;
      ex_load_q     <= 1'b0;
      latch_q       <= '0;
      lu_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      ex_valid_q    <= ex_valid_d;
      ex_rs_q       <= ex_rs_d;
      ex_rdata_q    <= ex_rdata_d;
      ex_imm_q      <= ex_imm_d;
      ex_alusrc_q   <= ex_alusrc_d;
      ex_rd_q       <= ex_rd_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_load_q     <= ex_load_d;
      latch_q       <= latch_d;
      lu_count_q    <= lu_count_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios then random traffic, compared
// against an instruction-level model; a second CNTW=2 instance checks saturation.
module tb_ex_operand_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ex_operand_stage_if #(.XLEN(32), .NSRC(2), .RADDR(5), .CNTW(16)) bus_a ();
  ex_operand_stage_if #(.XLEN(32), .NSRC(2), .RADDR(5), .CNTW(2))  bus_b ();

  ex_operand_stage #(.XLEN(32), .NSRC(2), .RADDR(5), .CNTW(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  ex_operand_stage #(.XLEN(32), .NSRC(2), .RADDR(5), .CNTW(2)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  assign bus_b.id_valid     = bus_a.id_valid;
  assign bus_b.id_rs        = bus_a.id_rs;
  assign bus_b.id_rdata     = bus_a.id_rdata;
  assign bus_b.id_imm       = bus_a.id_imm;
  assign bus_b.id_alusrc    = bus_a.id_alusrc;
  assign bus_b.id_rd        = bus_a.id_rd;
  assign bus_b.id_regwrite  = bus_a.id_regwrite;
  assign bus_b.id_load      = bus_a.id_load;
  assign bus_b.mem_rd       = bus_a.mem_rd;
  assign bus_b.mem_regwrite = bus_a.mem_regwrite;
  assign bus_b.mem_result   = bus_a.mem_result;
  assign bus_b.wb_rd        = bus_a.wb_rd;
  assign bus_b.wb_regwrite  = bus_a.wb_regwrite;
  assign bus_b.wb_result    = bus_a.wb_result;
  assign bus_b.ex_flush     = bus_a.ex_flush;
  assign bus_b.ext_stall    = bus_a.ext_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level model of what sits in EX
  logic        m_hold;
  logic        m_v, m_rw, m_ld, m_as;
  logic [4:0]  m_rd;
  logic [4:0]  m_rs[2];
  logic [31:0] m_rdata[2];
  logic [31:0] m_imm;
  logic [31:0] m_latch[2];
  int          m_cnt;
  logic [1:0]  e_fwd[2];
  logic [31:0] e_src[2];
  logic        e_lu;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_empty();
    m_v = 1'b0; m_rw = 1'b0; m_ld = 1'b0; m_as = 1'b0; m_rd = '0; m_imm = '0;
    for (int k = 0; k < 2; k++) begin
      m_rs[k] = '0;
      m_rdata[k] = '0;
    end
  endtask

  task automatic model_reset();
    model_empty();
    m_hold = 1'b0;
    m_cnt  = 0;
    m_latch[0] = '0;
    m_latch[1] = '0;
  endtask

  task automatic model_take_id();
    m_v        = bus_a.id_valid;
    m_rs[0]    = bus_a.id_rs[4:0];
    m_rs[1]    = bus_a.id_rs[9:5];
    m_rdata[0] = bus_a.id_rdata[31:0];
    m_rdata[1] = bus_a.id_rdata[63:32];
    m_imm      = bus_a.id_imm;
    m_as       = bus_a.id_alusrc;
    m_rd       = bus_a.id_rd;
    m_rw       = bus_a.id_valid && bus_a.id_regwrite;
    m_ld       = bus_a.id_valid && bus_a.id_load;
  endtask

  task automatic model_comb();
    for (int k = 0; k < 2; k++) begin
      e_fwd[k] = 2'b00;
      e_src[k] = m_rdata[k];
      if (m_hold) begin
        e_src[k] = m_latch[k];
      end else if (m_v && m_rs[k] != 0) begin
        if (bus_a.mem_regwrite && bus_a.mem_rd == m_rs[k]) begin
          e_fwd[k] = 2'b10;
          e_src[k] = bus_a.mem_result;
        end else if (bus_a.wb_regwrite && bus_a.wb_rd == m_rs[k]) begin
          e_fwd[k] = 2'b01;
          e_src[k] = bus_a.wb_result;
        end
      end
    end
    e_lu = m_v && m_ld && (m_rd != 0) && bus_a.id_valid &&
           (bus_a.id_rs[4:0] == m_rd || bus_a.id_rs[9:5] == m_rd);
  endtask

  task automatic eval();
    #1;
    model_comb();
    chk("stall_id",     bus_a.stall_id, m_hold || e_lu);
    chk("ex_valid",     bus_a.ex_valid, m_v);
    chk("ex_rd",        bus_a.ex_rd, m_rd);
    chk("ex_regwrite",  bus_a.ex_regwrite, m_rw);
    chk("ex_load",      bus_a.ex_load, m_ld);
    chk("ex_fwd",       bus_a.ex_fwd, {e_fwd[1], e_fwd[0]});
    chk("ex_src",       bus_a.ex_src, {e_src[1], e_src[0]});
    chk("ex_alu_b",     bus_a.ex_alu_b, m_as ? m_imm : e_src[1]);
    chk("ex_wdata",     bus_a.ex_wdata, e_src[1]);
    chk("lu_count",     bus_a.lu_count, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("lu_count_sat", bus_b.lu_count, (m_cnt > 3) ? 3 : m_cnt);
    chk("stall_id_sat", bus_b.stall_id, m_hold || e_lu);
  endtask

  task automatic adv();
    model_comb();
    assert (!(m_hold && bus_a.ex_flush)) else $error("ex_flush asserted during HOLD");
    if (rst) model_reset();
    else if (m_hold) begin
      if (!bus_a.ext_stall) begin
        m_hold = 1'b0;
        model_take_id();
      end
    end else if (bus_a.ext_stall) begin
      m_hold = 1'b1;
      m_latch[0] = e_src[0];
      m_latch[1] = e_src[1];
    end else if (bus_a.ex_flush) model_empty();
    else if (e_lu) begin
      model_empty();
      m_cnt++;
    end else model_take_id();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus_a.id_valid = 0; bus_a.id_rs = '0; bus_a.id_rdata = '0; bus_a.id_imm = '0;
    bus_a.id_alusrc = 0; bus_a.id_rd = '0; bus_a.id_regwrite = 0; bus_a.id_load = 0;
    bus_a.mem_rd = '0; bus_a.mem_regwrite = 0; bus_a.mem_result = '0;
    bus_a.wb_rd = '0; bus_a.wb_regwrite = 0; bus_a.wb_result = '0;
    bus_a.ex_flush = 0; bus_a.ext_stall = 0;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] imm,
                        input logic as, input logic [4:0] rd, input logic rw, input logic ld);
    bus_a.id_valid = v; bus_a.id_rs = {rs1, rs0}; bus_a.id_rdata = {d1, d0};
    bus_a.id_imm = imm; bus_a.id_alusrc = as; bus_a.id_rd = rd;
    bus_a.id_regwrite = rw; bus_a.id_load = ld;
  endtask

  task automatic drive_random();
    rst = ($urandom_range(0, 59) == 0);
    id_set($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    bus_a.mem_rd = 5'($urandom_range(0, 3));
    bus_a.mem_regwrite = $urandom_range(0, 1) == 1;
    bus_a.mem_result = $urandom;
    bus_a.wb_rd = 5'($urandom_range(0, 3));
    bus_a.wb_regwrite = $urandom_range(0, 1) == 1;
    bus_a.wb_result = $urandom;
    bus_a.ext_stall = m_hold ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
    bus_a.ex_flush = !m_hold && !bus_a.ext_stall && ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    adv();
    adv();
    rst = 1'b0;

    eval();
    chk("rst_lu_count", bus_a.lu_count, 16'd0);
    chk("rst_ex_src", bus_a.ex_src, 64'd0);

    // Forwarding priority
    id_set(1, 5, 3, 32'hAAAA, 32'hBBBB, 0, 0, 9, 1, 0);
    adv();
    bus_a.id_valid = 0;
    bus_a.mem_rd = 5; bus_a.mem_regwrite = 1; bus_a.mem_result = 32'h11;
    bus_a.wb_rd = 5;  bus_a.wb_regwrite = 1;  bus_a.wb_result = 32'h22;
    eval();
    chk("fwd_mem_sel", bus_a.ex_fwd[1:0], 2'b10);
    chk("fwd_mem_val", bus_a.ex_src[31:0], 32'h11);
    bus_a.mem_regwrite = 0;
    eval();
    chk("fwd_wb_sel", bus_a.ex_fwd[1:0], 2'b01);
    chk("fwd_wb_val", bus_a.ex_src[31:0], 32'h22);
    id_set(1, 0, 3, 32'h33, 32'h44, 0, 0, 9, 1, 0);
    adv();
    bus_a.id_valid = 0;
    bus_a.mem_rd = 0; bus_a.mem_regwrite = 1; bus_a.wb_rd = 0; bus_a.wb_regwrite = 1;
    eval();
    chk("fwd_x0_sel", bus_a.ex_fwd[1:0], 2'b00);
    chk("fwd_x0_val", bus_a.ex_src[31:0], 32'h33);

    // Load-use: lw x7 then add x8,x7,x1
    bus_a.mem_regwrite = 0; bus_a.wb_regwrite = 0;
    id_set(1, 1, 2, 0, 0, 0, 0, 7, 1, 1);
    adv();
    id_set(1, 7, 1, 32'h0, 32'h0, 0, 0, 8, 1, 0);
    eval();
    chk("lu_stall", bus_a.stall_id, 1'b1);
    adv();
    eval();
    chk("lu_bubble", bus_a.ex_valid, 1'b0);
    chk("lu_count1", bus_a.lu_count, 16'd1);
    adv();
    bus_a.id_valid = 0;
    bus_a.wb_rd = 7; bus_a.wb_regwrite = 1; bus_a.wb_result = 32'h5555;
    eval();
    chk("lu_fwd_sel", bus_a.ex_fwd[1:0], 2'b01);
    chk("lu_fwd_val", bus_a.ex_src[31:0], 32'h5555);

    // HOLD with channel-1 forward from WB
    bus_a.wb_regwrite = 0;
    id_set(1, 0, 4, 0, 0, 0, 0, 10, 1, 0);
    adv();
    bus_a.wb_rd = 4; bus_a.wb_regwrite = 1; bus_a.wb_result = 32'hDEADBEEF;
    bus_a.ext_stall = 1;
    id_set(1, 2, 3, 32'h1, 32'h2, 0, 0, 11, 1, 0);
    eval();
    chk("hold_pre", bus_a.ex_src[63:32], 32'hDEADBEEF);
    adv();
    bus_a.wb_result = 0; bus_a.wb_regwrite = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus_a.ext_stall = 0;
      eval();
      chk("hold_src", bus_a.ex_src[63:32], 32'hDEADBEEF);
      chk("hold_stall", bus_a.stall_id, 1'b1);
      chk("hold_fwd", bus_a.ex_fwd, 4'b0000);
      adv();
    end
    eval();
    chk("hold_exit_rd", bus_a.ex_rd, 5'd11);
    chk("hold_exit_valid", bus_a.ex_valid, 1'b1);

    // Flush beats load-use
    id_set(1, 1, 2, 0, 0, 0, 0, 7, 1, 1);
    adv();
    id_set(1, 7, 1, 0, 0, 0, 0, 8, 1, 0);
    bus_a.ex_flush = 1;
    eval();
    adv();
    bus_a.ex_flush = 0;
    bus_a.id_valid = 0;
    eval();
    chk("flush_valid", bus_a.ex_valid, 1'b0);
    chk("flush_lu_count", bus_a.lu_count, 16'd1);

    // Immediate mux and store data
    id_set(1, 0, 6, 0, 32'h1234, 32'h800, 1, 12, 1, 0);
    adv();
    bus_a.id_valid = 0;
    bus_a.mem_rd = 6; bus_a.mem_regwrite = 1; bus_a.mem_result = 32'hCAFE;
    eval();
    chk("alu_b_imm", bus_a.ex_alu_b, 32'h800);
    chk("wdata_fwd", bus_a.ex_wdata, 32'hCAFE);
    bus_a.mem_regwrite = 0;

    // Five more load-use bubbles
    for (int i = 0; i < 5; i++) begin
      id_set(1, 1, 2, 0, 0, 0, 0, 7, 1, 1);
      adv();
      id_set(1, 3, 7, 0, 0, 0, 0, 8, 1, 0);
      adv();
    end
    bus_a.id_valid = 0;
    eval();
    chk("sat_count", bus_b.lu_count, 2'd3);
    chk("nosat_count", bus_a.lu_count, 16'd6);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive_random();
      eval();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
